// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux scan sequencer.
//   N_CH    : number of channels behind the downstream mux (8)
//   SEL_W   : width of the channel select (3)
//   state_t : scan FSM state encoding
package mux_scan_sequencer_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/mux_scan_sequencer_prio_enc8.sv
// prio_enc8: lowest-set-bit encoder over an 8-bit vector.
// Ports:
//   vec  in  8  request vector
//   idx  out 3  index of the lowest set bit (0 when vec is empty)
//   none out 1  high when vec has no bit set
module prio_enc8
    import mux_scan_sequencer_pkg::*;
(
    input  logic [N_CH-1:0]  vec,
    output logic [SEL_W-1:0] idx,
    output logic             none
);

    // Walk from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx  = '0;
        none = 1'b1;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx  = SEL_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks the channels set in a latched mask through an
// external 8:1 mux, waits a programmable settle time on each, samples the
// mux output into a result byte and presents it with a valid/ready handshake.
// Ports:
//   clk       in  1         rising-edge clock
//   rst_n     in  1         synchronous active-low reset
//   start     in  1         scan request (IDLE only)
//   abort     in  1         cancel the scan in progress
//   ch_mask   in  8         channels to scan, latched at start
//   settle    in  SETTLE_W  extra wait cycles per channel, latched at start
//   mux_en    out 1         downstream mux enable
//   mux_sel   out 3         downstream mux select
//   mux_y     in  1         downstream mux output
//   busy      out 1         high whenever the FSM is not in IDLE
//   out_valid out 1         scan result valid
//   out_ready in  1         consumer accepts the result
//   out_data  out 8         one sampled bit per channel, unscanned bits 0
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int SETTLE_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [N_CH-1:0]     ch_mask,
    input  logic [SETTLE_W-1:0] settle,
    output logic                mux_en,
    output logic [SEL_W-1:0]    mux_sel,
    input  logic                mux_y,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_CH-1:0]     out_data
);

    state_t              state;
    state_t              next_state;
    logic [N_CH-1:0]     pending;
    logic [N_CH-1:0]     pending_left;
    logic [N_CH-1:0]     data;
    logic [SETTLE_W-1:0] settle_q;
    logic [SETTLE_W-1:0] cnt;
    logic [SEL_W-1:0]    idx_q;
    logic [SEL_W-1:0]    enc_idx;
    logic                enc_none;
    logic                handshake;
    logic                abort_hit;

    logic                mux_en_d;
    logic [SEL_W-1:0]    mux_sel_d;
    logic                busy_d;
    logic                out_valid_d;
    logic [N_CH-1:0]     out_data_d;

    prio_enc8 u_prio_enc8 (
        .vec  (pending),
        .idx  (enc_idx),
        .none (enc_none)
    );

    assign handshake = out_valid && out_ready;
    assign abort_hit = abort && (state != ST_IDLE);

    // Channels still to visit once the current one has been sampled.
    always_comb begin
        pending_left        = pending;
        pending_left[idx_q] = 1'b0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = (ch_mask == '0) ? ST_DONE : ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (enc_none) begin
                    next_state = ST_DONE;
                end else if (settle_q != '0) begin
                    next_state = ST_SETTLE;
                end else begin
                    next_state = ST_SAMPLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == SETTLE_W'(1)) begin
                    next_state = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                next_state = (pending_left != '0) ? ST_SELECT : ST_DONE;
            end
            ST_DONE: begin
                if (handshake) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (abort_hit) begin
            next_state = ST_IDLE;
        end
    end

    // Next values for the registered outputs.
    always_comb begin
        mux_en_d    = mux_en;
        mux_sel_d   = mux_sel;
        out_data_d  = out_data;
        busy_d      = (next_state != ST_IDLE);
        // Valid only from the second DONE cycle, so the result register has
        // been loaded by the time valid is seen.
        out_valid_d = (state == ST_DONE) && (next_state == ST_DONE);
        if ((next_state == ST_IDLE) || (next_state == ST_DONE)) begin
            mux_en_d  = 1'b0;
            mux_sel_d = '0;
        end else if (state == ST_SELECT) begin
            mux_en_d  = 1'b1;
            mux_sel_d = enc_idx;
        end
        // Load the result once, on entry into DONE, and hold it afterwards.
        if ((state == ST_DONE) && (next_state == ST_DONE) && !out_valid) begin
            out_data_d = data;
        end
    end

    // Scan datapath: latched request, settle counter and sampled bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending  <= '0;
            data     <= '0;
            settle_q <= '0;
            cnt      <= '0;
            idx_q    <= '0;
        end else if (abort_hit) begin
            pending <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pending  <= ch_mask;
                        settle_q <= settle;
                        data     <= '0;
                    end
                end
                ST_SELECT: begin
                    idx_q <= enc_idx;
                    cnt   <= settle_q;
                end
                ST_SETTLE: begin
                    cnt <= cnt - SETTLE_W'(1);
                end
                ST_SAMPLE: begin
                    data[idx_q] <= mux_y;
                    pending     <= pending_left;
                end
                default: ;
            endcase
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mux_en    <= 1'b0;
            mux_sel   <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            mux_en    <= mux_en_d;
            mux_sel   <= mux_sel_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed testbench for mux_scan_sequencer: a vector table of scans with
// hand-computed latency and result, plus backpressure, abort and reset
// sequences.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] ch_mask;
    logic [1:0] settle;
    logic       mux_en;
    logic [2:0] mux_sel;
    logic       mux_y;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    logic [7:0] a_model;   // value presented on the 8 mux inputs

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] mask;
        logic [1:0] settle;
        logic [7:0] a;
        int         edges;
        logic [7:0] data;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    assign mux_y = a_model[mux_sel];

    mux_scan_sequencer #(.SETTLE_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .ch_mask   (ch_mask),
        .settle    (settle),
        .mux_en    (mux_en),
        .mux_sel   (mux_sel),
        .mux_y     (mux_y),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse start for one edge, then scramble the request inputs so that
    // any use of unlatched values shows up in the result.
    task automatic start_scan(input logic [7:0] m, input logic [1:0] s);
        ch_mask = m;
        settle  = s;
        start   = 1'b1;
        step();
        start   = 1'b0;
        ch_mask = ~m;
        settle  = ~s;
    endtask

    // Count edges until out_valid; record visited channels and order.
    task automatic wait_valid(input logic [7:0] m, output int n, output logic sel_ok);
        logic [7:0] seen;
        int         last;
        n      = 0;
        seen   = '0;
        last   = -1;
        sel_ok = 1'b1;
        while (!out_valid && n < 100) begin
            if (mux_en) begin
                if (!m[mux_sel] || int'(mux_sel) < last) sel_ok = 1'b0;
                seen[mux_sel] = 1'b1;
                last = int'(mux_sel);
            end
            step();
            n++;
        end
        if (seen != m) sel_ok = 1'b0;
    endtask

    initial begin
        int         n;
        logic       sel_ok;
        logic       flag;

        vecs[0] = '{mask: 8'hFF, settle: 2'd0, a: 8'hA5, edges: 17, data: 8'hA5};
        vecs[1] = '{mask: 8'h81, settle: 2'd3, a: 8'hFF, edges: 11, data: 8'h81};
        vecs[2] = '{mask: 8'h00, settle: 2'd0, a: 8'hA5, edges: 1,  data: 8'h00};
        vecs[3] = '{mask: 8'h0F, settle: 2'd1, a: 8'h5A, edges: 13, data: 8'h0A};
        vecs[4] = '{mask: 8'h80, settle: 2'd2, a: 8'h80, edges: 5,  data: 8'h80};
        vecs[5] = '{mask: 8'h3C, settle: 2'd0, a: 8'hF0, edges: 9,  data: 8'h30};

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        ch_mask   = 8'h00;
        settle    = 2'd0;
        out_ready = 1'b0;
        a_model   = 8'h00;
        step();
        step();
        chk("reset_outputs", {31'd0, mux_en} | {29'd0, mux_sel} | {24'd0, out_data}, 32'd0);
        chk("reset_busy_valid", {30'd0, busy, out_valid}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Table of complete scans.
        for (int v = 0; v < 6; v++) begin
            a_model = vecs[v].a;
            start_scan(vecs[v].mask, vecs[v].settle);
            wait_valid(vecs[v].mask, n, sel_ok);
            chk($sformatf("v%0d_edges", v), n, vecs[v].edges);
            chk($sformatf("v%0d_data", v), {24'd0, out_data}, {24'd0, vecs[v].data});
            chk($sformatf("v%0d_sel", v), {31'd0, sel_ok}, 32'd1);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk($sformatf("v%0d_idle", v), {22'd0, busy, out_valid, out_data},
                {24'd0, vecs[v].data});
        end

        // Mux select must be held settle+1 cycles: with settle=3, channel 7
        // is selected after edges 6..9 of the scan.
        a_model = 8'hFF;
        start_scan(8'h81, 2'd3);
        repeat (5) step();
        flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (!mux_en || mux_sel != 3'd7) flag = 1'b0;
        end
        chk("sel_hold_ch7", {31'd0, flag}, 32'd1);
        step();
        chk("done_mux_off", {28'd0, mux_en, mux_sel}, 32'd0);
        step();
        chk("done_valid", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h81});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Backpressure with start pulsed while the result waits.
        a_model = 8'h02;
        start_scan(8'h03, 2'd0);
        wait_valid(8'h03, n, sel_ok);
        chk("bp_edges", n, 5);
        for (int i = 0; i < 5; i++) begin
            ch_mask = 8'hFF;
            start   = (i == 2);
            step();
            chk($sformatf("bp_hold%0d", i), {22'd0, busy, out_valid, out_data},
                {22'd0, 2'b11, 8'h02});
        end
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start     = 1'b0;
        out_ready = 1'b0;
        chk("bp_release", {30'd0, busy, out_valid}, 32'd0);
        step();
        chk("bp_no_restart", {30'd0, busy, mux_en}, 32'd0);

        // Abort during the settle phase of the third channel.
        a_model = 8'hFF;
        start_scan(8'hFF, 2'd2);
        repeat (9) step();
        chk("ab_third_ch", {28'd0, mux_en, mux_sel}, {28'd0, 1'b1, 3'd2});
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_idle", {29'd0, busy, mux_en, out_valid}, 32'd0);
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid || busy) flag = 1'b1;
        end
        chk("ab_no_valid", {31'd0, flag}, 32'd0);
        chk("ab_data_kept", {24'd0, out_data}, {24'd0, 8'h02});
        a_model = 8'h01;
        start_scan(8'h01, 2'd0);
        wait_valid(8'h01, n, sel_ok);
        chk("ab_next_edges", n, 3);
        chk("ab_next_data", {24'd0, out_data}, {24'd0, 8'h01});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset asserted for one edge while a channel is being sampled.
        a_model = 8'hFF;
        start_scan(8'hFF, 2'd0);
        repeat (3) step();
        chk("rs_scanning", {30'd0, busy, mux_en}, 32'd3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rs_outputs", {19'd0, mux_en, mux_sel, busy, out_valid, out_data}, 32'd0);
        step();
        chk("rs_stays_idle", {30'd0, busy, mux_en}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 The block SHALL have one parameter: SETTLE_W, default 2, width of the settle-cycle field.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  input  1  single clock, rising edge.
  rst_n  input  1  synchronous active-low reset.
  start  input  1  scan request, accepted only in IDLE.
  abort  input  1  cancel the scan in progress.
  ch_mask  input  8  channels to scan, latched at start.
  settle  input  SETTLE_W  extra wait cycles before each sample, latched at start.
  mux_en  output  1  enable to the downstream 8:1 mux.
  mux_sel  output  3  channel select to the 8:1 mux.
  mux_y  input  1  8:1 mux output.
  busy  output  1  high in every state except IDLE.
  out_valid  output  1  scan result valid.
  out_ready  input  1  consumer accepts the result.
  out_data  output  8  sampled bit per channel; unscanned bits are 0.

Function
REQ-004 The FSM SHALL have the states IDLE, SELECT, SETTLE, SAMPLE and DONE, all registered.
REQ-005 IDLE with start=1 and ch_mask!=0 SHALL latch ch_mask into pending, latch settle, clear the data register and go to SELECT.
REQ-006 IDLE with start=1 and ch_mask==0 SHALL go directly to DONE with out_data=0.
REQ-007 SELECT SHALL pick the lowest set bit of pending as idx, register mux_sel=idx and mux_en=1, load the settle counter, and go to SETTLE if settle>0, else to SAMPLE.
REQ-008 SETTLE SHALL decrement the counter and go to SAMPLE after exactly settle cycles.
REQ-009 SAMPLE SHALL write mux_y into data[idx] and clear pending[idx]; if pending is still non-zero it SHALL go to SELECT, else it SHALL go to DONE.
REQ-010 Each channel SHALL take exactly 2+settle cycles, and mux_sel SHALL be stable for settle+1 cycles before the sampling edge.
REQ-011 With k channels, out_valid SHALL rise 1+k*(2+settle) edges after the edge that samples start.
REQ-012 In DONE, out_valid SHALL be 1 and mux_en SHALL be 0; out_data SHALL hold stable until out_valid&&out_ready, then the FSM SHALL return to IDLE on that edge.
REQ-013 start while busy=1 SHALL be ignored, including the same edge as the out_valid&&out_ready handshake.
REQ-014 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with mux_en=0, out_valid=0, and the result discarded.
REQ-015 abort SHALL take priority over SAMPLE capture and over the handshake.
REQ-016 In IDLE, mux_en SHALL be 0, mux_sel SHALL be 0 and out_data SHALL hold its last accepted value.
REQ-017 mux_sel SHALL never address a channel whose bit is 0 in the latched mask.
REQ-018 Changes to ch_mask and settle mid-scan SHALL have no effect.

Reset
REQ-019 While rst_n=0 at a rising edge, the block SHALL go to IDLE, with mux_en=0, mux_sel=0, busy=0, out_valid=0, out_data=0, pending=0 and the counter at 0.
REQ-020 Reset SHALL take priority over start, abort and the handshake, including in the middle of a scan.
REQ-021 No output SHALL change asynchronously to clk.

Structure
REQ-022 A shared package SHALL hold the FSM state enum and the constants N_CH=8 and SEL_W=3.
REQ-023 One sub-module, prio_enc8 (8-bit lowest-set-bit encoder, 3-bit index plus a none flag), SHALL be used for idx selection.
REQ-024 All outputs SHALL be driven from registers.

Verification
REQ-025 Full scan: mux model a=8'hA5, ch_mask=8'hFF, settle=0, out_ready=1 -> mux_sel steps 0..7, out_valid=1 at edge 17 after start, out_data=8'hA5.
REQ-026 Sparse scan with settle: a=8'hFF, ch_mask=8'h81, settle=3 -> only channels 0 and 7 selected, each for 5 cycles, out_valid at edge 11, out_data=8'h81.
REQ-027 Empty mask: ch_mask=8'h00 -> mux_en never 1, out_valid at edge 1, out_data=8'h00.
REQ-028 Backpressure: out_ready=0 for 5 cycles in DONE and start pulsed during them -> out_valid and out_data held stable; the FSM returns to IDLE only on the ready edge and no second scan starts.
REQ-029 Abort: abort=1 during SETTLE of the third channel -> IDLE on the next edge, mux_en=0, no out_valid pulse; a following start with ch_mask=8'h01 completes normally.
REQ-030 Reset mid-scan: rst_n=0 for one edge during SAMPLE -> every output at its REQ-019 value on the next cycle and busy=0.
